core_seq: RTL and testbench
===========================

# core_seq

Instruction sequencer for the attention core. It turns a single `start` pulse plus a streamed operand load into the full 27-bit `inst` sequence and aligned `mem_in` data for one Q×K tile:

- load V/N memories
- kernel load
- execute
- OFIFO drain into psum memory
- two-pass (accumulate, then divide) normalization into norm memory

It sits between the testbench/host stream and `core`, and replaces hand-written instruction vectors.

## Interface
Parameters:
- `bw`, 4, activation/weight bit width
- `pr`, 8, rows per operand word; `mem_in` width = `pr*bw*2`
- `Q_ROWS`, 8, rows written to vmem and executed (≤16)
- `K_ROWS`, 8, rows written to nmem and kernel-loaded (≤16)
- `SFP_LAT`, 1, cycles from psum-mem `Q` valid to `sfp_row` output valid

Ports:
- `clk` input 1: clock
- `reset` input 1: synchronous, active-high
- `start` input 1: one-cycle pulse; accepted only in IDLE
- `col_c_mode` input 1: sampled with `start`; selects 8b column-combine normalization
- `in_data` input `pr*bw*2`: operand row stream
- `in_valid` input 1: `in_data` valid
- `in_ready` output 1: block accepts a row this cycle
- `ofifo_valid` input 1: `core` OFIFO `o_valid`, exported by the integration
- `inst` output 27: instruction word to `core`
- `mem_in` output `pr*bw*2`: data to `core`, aligned with `inst`
- `busy` output 1: high in any state other than IDLE
- `done` output 1: one-cycle pulse at the end of the tile

## Operation
- **Output timing.** All outputs are registered. Reset drives `inst`, `mem_in`, `in_ready`, `busy` and `done` to 0 and the FSM to IDLE. Reset mid-tile aborts immediately, with no drain.
- **Field map of `inst`:**
  - `[26:23]` norm_add, `[22]` norm_wr, `[21]` norm_rd, `[20]` norm, `[19]` div, `[18]` acc, `[17]` col_c, `[16]` ofifo_rd
  - `[15:12]` vnmem_add, `[11:8]` pmem_add, `[7]` execute, `[6]` kernel-load/nmem select
  - `[5]` vmem_rd, `[4]` vmem_wr, `[3]` nmem_rd, `[2]` nmem_wr, `[1]` pmem_rd, `[0]` pmem_wr
  - Unlisted fields are 0.
- **States:** IDLE → LOAD_V → LOAD_N → KLOAD → GAP → EXEC → DRAIN_RD ⇄ DRAIN_WR → ACC → DIV → FLUSH → DONE → IDLE.
- **LOAD_V.**
  - `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) on row r produces, next cycle: `vmem_wr`=1, `vnmem_add`=r, `mem_in`=`in_data`.
  - No handshake gives `inst`=0.
  - After row `Q_ROWS-1` the FSM goes to LOAD_N and `in_ready` stays 1.
- **LOAD_N.** Same as LOAD_V with `nmem_wr`, for `K_ROWS` rows. `in_ready` drops after the last handshake.
- **KLOAD.** For k=0..`K_ROWS-1`: `nmem_rd`=1, `inst[6]`=1, `vnmem_add`=k.
- **GAP.** One cycle with `inst`=0.
- **EXEC.** For q=0..`Q_ROWS-1`: `vmem_rd`=1, `inst[7]`=1, `vnmem_add`=q.
- **Drain.**
  - DRAIN_RD waits for `ofifo_valid`. It then emits `ofifo_rd`=1 for one cycle.
  - DRAIN_WR follows with `pmem_wr`=1, `pmem_add`=i, then i++.
  - The loop ends after `Q_ROWS` writes.
  - `ofifo_rd` is never asserted when `ofifo_valid`=0.
- **ACC.**
  - For i=0..`Q_ROWS-1`: `pmem_rd`=1, `pmem_add`=i, `norm`=1, `acc`=1.
  - `col_c` = latched `col_c_mode` throughout ACC/DIV/FLUSH.
- **DIV.**
  - For i=0..`Q_ROWS-1`: `pmem_rd`=1, `pmem_add`=i, `norm`=1, `div`=1.
  - Row i is pushed into a delay line of depth `SFP_LAT+1`.
  - A row leaving the delay line drives `norm_wr`=1, `norm_add`=i.
- **FLUSH.** `SFP_LAT+1` cycles with `norm`=1, `div`=1, no `pmem_rd`, until the delay line is empty.
- **DONE.** `done`=1 for one cycle with `inst`=0, then IDLE.
- **Ignored inputs.** `start` is ignored outside IDLE. `in_valid` is ignored when `in_ready`=0.

## Timing
- `start` sampled at edge t: `busy`=1 and `in_ready`=1 from t+1.
- Handshake-to-write latency: 1 cycle.
- Execute phase (KLOAD+GAP+EXEC): exactly `K_ROWS+1+Q_ROWS` cycles.
- Drain: 2 cycles per row minimum; a stalled `ofifo_valid` stalls with `inst`=0.
- Normalization: `Q_ROWS` (ACC) + `Q_ROWS` (DIV) + `SFP_LAT+1` (FLUSH) cycles.
- norm_wr for row i is asserted exactly `SFP_LAT+1` cycles after its DIV `pmem_rd` cycle.
- Counters are 4-bit and never wrap within a phase; each resets to 0 on phase entry.

## Structure
- Package `core_seq_pkg`: `inst` field bit-position constants, FSM state enum, `INST_W`=27.
- Sub-module `norm_wr_delay`: a shift register of {valid, 4-bit addr}, depth `SFP_LAT+1`, with synchronous reset.

## Test plan
- **Full tile.** `Q_ROWS`=`K_ROWS`=8, `in_valid` held 1, `ofifo_valid` held 1, `col_c_mode`=0.
  - vmem_wr at addr 0..7, then nmem_wr at 0..7, KLOAD 8 cycles, GAP 1 cycle, EXEC 8 cycles, 8 rd/wr drain pairs.
  - norm_wr with norm_add 0..7, each 2 cycles after its DIV read; `done` pulses once.
- **Stream bubbles.** Toggle `in_valid` 1,0,1,0.
  - vmem_wr only on accepted rows; addresses contiguous 0..7; `mem_in` equals the accepted `in_data`.
- **OFIFO stall.** Hold `ofifo_valid`=0 for 20 cycles in DRAIN_RD.
  - `inst`=0 throughout; no `ofifo_rd`; drain resumes on 1.
- **col_c mode.** Set `col_c_mode`=1 at `start`.
  - `inst[17]`=1 in every ACC/DIV/FLUSH cycle and 0 elsewhere.
- **Reset mid-EXEC.** Assert `reset` during EXEC row 3.
  - Next cycle: `inst`=0, `busy`=0, `in_ready`=0.
  - A new `start` restarts at LOAD_V addr 0.
- **start while busy.** Pulse `start` during DRAIN.
  - Ignored; exactly one `done` pulse.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared definitions for the attention-core instruction sequencer:
// instruction field positions, FSM states and word-building helpers.
package core_seq_pkg;

  localparam int INST_W = 27;

  localparam int NORM_ADD_LSB = 23;
  localparam int NORM_WR_BIT  = 22;
  localparam int NORM_BIT     = 20;
  localparam int DIV_BIT      = 19;
  localparam int ACC_BIT      = 18;
  localparam int COL_C_BIT    = 17;
  localparam int OFIFO_RD_BIT = 16;
  localparam int VN_ADD_LSB   = 12;
  localparam int PMEM_ADD_LSB = 8;
  localparam int EXEC_BIT     = 7;
  localparam int KLOAD_BIT    = 6;
  localparam int VMEM_RD_BIT  = 5;
  localparam int VMEM_WR_BIT  = 4;
  localparam int NMEM_RD_BIT  = 3;
  localparam int NMEM_WR_BIT  = 2;
  localparam int PMEM_RD_BIT  = 1;
  localparam int PMEM_WR_BIT  = 0;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD_V   = 4'd1,
    S_LOAD_N   = 4'd2,
    S_KLOAD    = 4'd3,
    S_GAP      = 4'd4,
    S_EXEC     = 4'd5,
    S_DRAIN_RD = 4'd6,
    S_DRAIN_WR = 4'd7,
    S_ACC      = 4'd8,
    S_DIV      = 4'd9,
    S_FLUSH    = 4'd10,
    S_DONE     = 4'd11
  } state_t;

  function automatic logic [INST_W-1:0] flag(input int pos);
    return {{(INST_W-1){1'b0}}, 1'b1} << pos;
  endfunction

  function automatic logic [INST_W-1:0] field4(input logic [3:0] val, input int lsb);
    return {{(INST_W-4){1'b0}}, val} << lsb;
  endfunction

endpackage

// File: rtl/core_seq_norm_wr_delay.sv
// Delay line that re-times each DIV-phase psum read into the matching
// norm-memory write once the SFP result is valid.
module norm_wr_delay #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [3:0] push_addr,
  output logic       pop_valid,
  output logic [3:0] pop_addr
);

  logic [DEPTH-1:0] valid_r;
  logic [3:0]       addr_r [DEPTH];

  // Shift {valid, addr} one stage per cycle; the tail feeds the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) addr_r[i] <= 4'd0;
    end else begin
      valid_r[0] <= push_valid;
      addr_r[0]  <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        addr_r[i]  <= addr_r[i-1];
      end
    end
  end

  assign pop_valid = valid_r[DEPTH-1];
  assign pop_addr  = addr_r[DEPTH-1];

endmodule

// File: rtl/core_seq.sv
// Instruction sequencer: expands one start pulse and a streamed operand load
// into the complete load / execute / drain / normalize sequence for one tile.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int bw      = 4,
  parameter int pr      = 8,
  parameter int Q_ROWS  = 8,
  parameter int K_ROWS  = 8,
  parameter int SFP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 col_c_mode,
  input  logic [pr*bw*2-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ofifo_valid,
  output logic [INST_W-1:0]    inst,
  output logic [pr*bw*2-1:0]   mem_in,
  output logic                 busy,
  output logic                 done
);

  localparam int DW = pr*bw*2;
  localparam logic [3:0] Q_LAST = 4'(Q_ROWS-1);
  localparam logic [3:0] K_LAST = 4'(K_ROWS-1);
  localparam logic [3:0] F_LAST = 4'(SFP_LAT);

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                col_c_r;
  logic                hs_s;
  logic                pop_valid_s;
  logic [3:0]          pop_addr_s;
  logic [INST_W-1:0]   col_c_s;
  logic [INST_W-1:0]   norm_wr_s;
  logic [INST_W-1:0]   norm_base_s;

  assign hs_s        = in_valid & in_ready;
  assign col_c_s     = col_c_r ? flag(COL_C_BIT) : {INST_W{1'b0}};
  assign norm_wr_s   = pop_valid_s ? (flag(NORM_WR_BIT) | field4(pop_addr_s, NORM_ADD_LSB))
                                   : {INST_W{1'b0}};
  assign norm_base_s = flag(NORM_BIT) | col_c_s;

  norm_wr_delay #(.DEPTH(SFP_LAT+1)) u_norm_wr_delay (
    .clk        (clk),
    .reset      (reset),
    .push_valid (state_r == S_DIV),
    .push_addr  (cnt_r),
    .pop_valid  (pop_valid_s),
    .pop_addr   (pop_addr_s)
  );

  // Sequencer FSM; every output is registered and defaults to an idle word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      col_c_r  <= 1'b0;
      inst     <= {INST_W{1'b0}};
      mem_in   <= {DW{1'b0}};
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inst   <= {INST_W{1'b0}};
      mem_in <= {DW{1'b0}};
      done   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r  <= S_LOAD_V;
            cnt_r    <= 4'd0;
            col_c_r  <= col_c_mode;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD_V: begin
          if (hs_s) begin
            inst   <= flag(VMEM_WR_BIT) | field4(cnt_r, VN_ADD_LSB);
            mem_in <= in_data;
            if (cnt_r == Q_LAST) begin
              state_r <= S_LOAD_N;
              cnt_r   <= 4'd0;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        S_LOAD_N: begin
          if (hs_s) begin
            inst   <= flag(NMEM_WR_BIT) | field4(cnt_r, VN_ADD_LSB);
            mem_in <= in_data;
            if (cnt_r == K_LAST) begin
              state_r  <= S_KLOAD;
              cnt_r    <= 4'd0;
              in_ready <= 1'b0;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        S_KLOAD: begin
          inst <= flag(NMEM_RD_BIT) | flag(KLOAD_BIT) | field4(cnt_r, VN_ADD_LSB);
          if (cnt_r == K_LAST) begin
            state_r <= S_GAP;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_GAP: begin
          state_r <= S_EXEC;
          cnt_r   <= 4'd0;
        end
        S_EXEC: begin
          inst <= flag(VMEM_RD_BIT) | flag(EXEC_BIT) | field4(cnt_r, VN_ADD_LSB);
          if (cnt_r == Q_LAST) begin
            state_r <= S_DRAIN_RD;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        // An empty OFIFO holds the drain here with an idle word.
        S_DRAIN_RD: begin
          if (ofifo_valid) begin
            inst    <= flag(OFIFO_RD_BIT);
            state_r <= S_DRAIN_WR;
          end
        end
        S_DRAIN_WR: begin
          inst <= flag(PMEM_WR_BIT) | field4(cnt_r, PMEM_ADD_LSB);
          if (cnt_r == Q_LAST) begin
            state_r <= S_ACC;
            cnt_r   <= 4'd0;
          end else begin
            state_r <= S_DRAIN_RD;
            cnt_r   <= cnt_r + 4'd1;
          end
        end
        S_ACC: begin
          inst <= norm_base_s | flag(ACC_BIT) | flag(PMEM_RD_BIT) | field4(cnt_r, PMEM_ADD_LSB);
          if (cnt_r == Q_LAST) begin
            state_r <= S_DIV;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_DIV: begin
          inst <= norm_base_s | flag(DIV_BIT) | flag(PMEM_RD_BIT)
                | field4(cnt_r, PMEM_ADD_LSB) | norm_wr_s;
          if (cnt_r == Q_LAST) begin
            state_r <= S_FLUSH;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_FLUSH: begin
          inst <= norm_base_s | flag(DIV_BIT) | norm_wr_s;
          if (cnt_r == F_LAST) begin
            state_r <= S_DONE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          col_c_r <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          cnt_r    <= 4'd0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq: full tiles with stream bubbles,
// OFIFO stall, col_c mode, mid-execute reset and start while busy.
module tb_core_seq;

  localparam int DW = 64;

  localparam logic [26:0] M_NORM_WR  = 27'h0400000;
  localparam logic [26:0] M_NORM     = 27'h0100000;
  localparam logic [26:0] M_DIV      = 27'h0080000;
  localparam logic [26:0] M_ACC      = 27'h0040000;
  localparam logic [26:0] M_COLC     = 27'h0020000;
  localparam logic [26:0] M_OFIFO_RD = 27'h0010000;
  localparam logic [26:0] M_EXE      = 27'h0000080;
  localparam logic [26:0] M_KL       = 27'h0000040;
  localparam logic [26:0] M_VMEM_RD  = 27'h0000020;
  localparam logic [26:0] M_VMEM_WR  = 27'h0000010;
  localparam logic [26:0] M_NMEM_RD  = 27'h0000008;
  localparam logic [26:0] M_NMEM_WR  = 27'h0000004;
  localparam logic [26:0] M_PMEM_RD  = 27'h0000002;
  localparam logic [26:0] M_PMEM_WR  = 27'h0000001;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          col_c_mode;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ofifo_valid;
  logic [26:0]   inst;
  logic [DW-1:0] mem_in;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  core_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .col_c_mode  (col_c_mode),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .mem_in      (mem_in),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [26:0] vn(input int a);
    return 27'(a) << 12;
  endfunction

  function automatic logic [26:0] pa(input int a);
    return 27'(a) << 8;
  endfunction

  function automatic logic [26:0] na(input int a);
    return 27'(a) << 23;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input logic colc, input logic bubbles, input int stall,
                          input int abort_q, input logic poke_start);
    int          r;
    int          dc0;
    logic        v;
    logic [26:0] cc;
    logic [63:0] d;
    cc  = colc ? M_COLC : 27'd0;
    dc0 = done_cnt;
    col_c_mode = colc;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    col_c_mode = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ready", 64'(in_ready), 64'd1);
    chk("start_inst", 64'(inst), 64'd0);

    for (int ph = 0; ph < 2; ph++) begin
      r = 0;
      v = 1'b1;
      while (r < 8) begin
        d        = 64'h0123_4567_89AB_0000 | 64'(ph*16 + r);
        in_valid = v;
        in_data  = v ? d : 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        if (v) begin
          chk("load_inst", 64'(inst), 64'((ph == 0 ? M_VMEM_WR : M_NMEM_WR) | vn(r)));
          chk("load_data", mem_in, d);
          r++;
        end else begin
          chk("load_bubble", 64'(inst), 64'd0);
        end
        if (bubbles) v = ~v;
      end
      chk("load_ready", 64'(in_ready), 64'(ph == 0));
    end

    in_valid = 1'b1;
    in_data  = 64'hFFFF_0000_FFFF_0000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("kload", 64'(inst), 64'(M_NMEM_RD | M_KL | vn(k)));
    end
    tick();
    chk("gap", 64'(inst), 64'd0);
    for (int q = 0; q < 8; q++) begin
      tick();
      chk("exec", 64'(inst), 64'(M_VMEM_RD | M_EXE | vn(q)));
      if (q == abort_q) begin
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("abort_inst", 64'(inst), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd0);
        return;
      end
    end

    in_valid    = 1'b0;
    ofifo_valid = (stall > 0) ? 1'b0 : 1'b1;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_inst", 64'(inst), 64'd0);
    end
    ofifo_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (poke_start && i == 3) start = 1'b1;
      tick();
      start = 1'b0;
      chk("drain_rd", 64'(inst), 64'(M_OFIFO_RD));
      tick();
      chk("drain_wr", 64'(inst), 64'(M_PMEM_WR | pa(i)));
    end

    for (int i = 0; i < 8; i++) begin
      tick();
      chk("acc", 64'(inst), 64'(M_PMEM_RD | pa(i) | M_NORM | M_ACC | cc));
    end
    // With SFP_LAT=1 row i is written two cycles after its DIV read.
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("div", 64'(inst), 64'(M_PMEM_RD | pa(i) | M_NORM | M_DIV | cc
                               | ((i >= 2) ? (M_NORM_WR | na(i-2)) : 27'd0)));
    end
    for (int f = 0; f < 2; f++) begin
      tick();
      chk("flush", 64'(inst), 64'(M_NORM | M_DIV | cc | M_NORM_WR | na(6+f)));
    end
    tick();
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_inst", 64'(inst), 64'd0);
    tick();
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_inst", 64'(inst), 64'd0);
    tick();
    chk("done_count", 64'(done_cnt - dc0), 64'd1);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    col_c_mode  = 1'b0;
    in_valid    = 1'b0;
    in_data     = 64'd0;
    ofifo_valid = 1'b1;
    tick();
    tick();
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_mem_in", mem_in, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    run_tile(1'b0, 1'b0, 0, -1, 1'b0);
    run_tile(1'b0, 1'b1, 0, -1, 1'b0);
    run_tile(1'b0, 1'b0, 20, -1, 1'b0);
    run_tile(1'b1, 1'b0, 0, -1, 1'b0);
    run_tile(1'b0, 1'b0, 0, 3, 1'b0);
    run_tile(1'b0, 1'b0, 0, -1, 1'b0);
    run_tile(1'b0, 1'b0, 0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
